// File: rtl/fnd_pkg.sv
// Shared constants for the FND display stage: segment fonts, operator codes
// and the all-off digit-enable pattern. Fonts are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [3:0] COM_OFF = 4'b1111;

   localparam logic [7:0] FONT_0     = 8'hC0;
   localparam logic [7:0] FONT_1     = 8'hF9;
   localparam logic [7:0] FONT_2     = 8'hA4;
   localparam logic [7:0] FONT_3     = 8'hB0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hF8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_BLANK = 8'hFF;

   localparam logic [7:0] FONT_OP_ADD = 8'h88;
   localparam logic [7:0] FONT_OP_SUB = 8'hBF;
   localparam logic [7:0] FONT_OP_MUL = 8'h89;
   localparam logic [7:0] FONT_OP_DIV = 8'hA1;

   // Any code the decoder does not map to a numeral renders dark.
   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   function automatic logic [7:0] op_symbol(input logic [1:0] op);
      logic [7:0] font;
      case (op)
         OP_ADD:  font = FONT_OP_ADD;
         OP_SUB:  font = FONT_OP_SUB;
         OP_MUL:  font = FONT_OP_MUL;
         default: font = FONT_OP_DIV;
      endcase
      return font;
   endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational numeral-to-segment decoder; codes 10..15 render blank.
module fnd_font_decoder
   import fnd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] font
);

   always_comb begin
      font = FONT_BLANK;
      case (digit)
         4'd0:    font = FONT_0;
         4'd1:    font = FONT_1;
         4'd2:    font = FONT_2;
         4'd3:    font = FONT_3;
         4'd4:    font = FONT_4;
         4'd5:    font = FONT_5;
         4'd6:    font = FONT_6;
         4'd7:    font = FONT_7;
         4'd8:    font = FONT_8;
         4'd9:    font = FONT_9;
         default: font = FONT_BLANK;
      endcase
   end

endmodule

// File: rtl/fnd_result_scanner.sv
// Captures a calculator result/operator and scans it onto a 4-digit
// common-anode FND: digit3 operator, digit2 blank, digit1 tens, digit0 ones.
module fnd_result_scanner
   import fnd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [3:0] i_result,
   input  logic [1:0] i_selOperatior,
   output logic [3:0] o_fndCom,
   output logic [7:0] o_fndFont
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] prescaler;
   logic [1:0]    digit_idx;
   logic [3:0]    r_value;
   logic [1:0]    r_op;
   logic          tick;
   logic          tens;
   logic [3:0]    ones;
   logic [3:0]    digit_sel;
   logic [7:0]    digit_font;
   logic [7:0]    font_next;

   assign tick = (prescaler == PW'(SCAN_DIV - 1));

   // Results never exceed 15, so the tens digit is at most 1.
   assign tens = (r_value >= 4'd10);
   assign ones = tens ? (r_value - 4'd10) : r_value;

   always_comb begin
      digit_sel = DIGIT_BLANK;
      case (digit_idx)
         2'd0:    digit_sel = ones;
         2'd1:    digit_sel = tens ? 4'd1 : DIGIT_BLANK;
         default: digit_sel = DIGIT_BLANK;
      endcase
   end

   fnd_font_decoder u_font_decoder (
      .digit (digit_sel),
      .font  (digit_font)
   );

   assign font_next = (digit_idx == 2'd3) ? op_symbol(r_op) : digit_font;

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         digit_idx <= 2'd0;
         r_value   <= 4'd0;
         r_op      <= OP_ADD;
         o_fndCom  <= COM_OFF;
         o_fndFont <= FONT_BLANK;
      end else begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick) begin
            digit_idx <= digit_idx + 2'd1;
         end
         if (i_load) begin
            r_value <= i_result;
            r_op    <= i_selOperatior;
         end
         // Enable and font are both built from pre-edge state so they switch together.
         o_fndCom  <= ~(4'b0001 << digit_idx);
         o_fndFont <= font_next;
      end
   end

endmodule

// File: tb/tb_fnd_result_scanner.sv
// Self-checking bench for fnd_result_scanner with a fast scan (SCAN_DIV=4).
module tb_fnd_result_scanner;

   localparam int SCAN_DIV = 4;

   logic       clk;
   logic       reset;
   logic       i_load;
   logic [3:0] i_result;
   logic [1:0] i_selOperatior;
   logic [3:0] o_fndCom;
   logic [7:0] o_fndFont;

   int checks = 0;
   int errors = 0;

   logic [7:0] digit_font [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   logic [7:0] op_font    [4]  = '{8'h88, 8'hBF, 8'h89, 8'hA1};
   logic [3:0] com_tbl    [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

   fnd_result_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_load         (i_load),
      .i_result       (i_result),
      .i_selOperatior (i_selOperatior),
      .o_fndCom       (o_fndCom),
      .o_fndFont      (o_fndFont)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: the display position follows from how many edges have
   // elapsed since reset release; contents follow from the last captured value.
   initial begin
      int         m_value;
      int         m_op;
      int         m_n;
      int         slot;
      bit         valid;
      bit         dark;
      logic [3:0] exp_com;
      logic [7:0] exp_font;
      logic       s_rst, s_load;
      logic [3:0] s_res;
      logic [1:0] s_op;
      valid = 0; dark = 1; m_value = 0; m_op = 0; m_n = 0;
      exp_com = 4'hF; exp_font = 8'hFF;
      forever begin
         @(posedge clk);
         s_rst = reset; s_load = i_load; s_res = i_result; s_op = i_selOperatior;
         if (s_rst === 1'b1) begin
            valid = 1; dark = 1;
            m_value = 0; m_op = 0; m_n = 0;
            exp_com = 4'hF; exp_font = 8'hFF;
         end else begin
            dark = 0;
            slot = (m_n / SCAN_DIV) % 4;
            exp_com = com_tbl[slot];
            case (slot)
               0:       exp_font = digit_font[m_value % 10];
               1:       exp_font = (m_value >= 10) ? digit_font[m_value / 10] : 8'hFF;
               2:       exp_font = 8'hFF;
               default: exp_font = op_font[m_op];
            endcase
            m_n++;
            if (s_load === 1'b1) begin
               m_value = int'(s_res);
               m_op    = int'(s_op);
            end
         end
         @(negedge clk);
         if (valid) begin
            check("model_com", {4'h0, o_fndCom}, {4'h0, exp_com});
            check("model_font", o_fndFont, exp_font);
            if (!dark) begin
               check("one_hot_zero", 8'($countones(~o_fndCom)), 8'd1);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [3:0] com, input logic [7:0] font);
      check({name, "_com"}, {4'h0, o_fndCom}, {4'h0, com});
      check({name, "_font"}, o_fndFont, font);
   endtask

   // Advance at least one edge, then wait (bounded) for a given digit slot.
   task automatic lit_slot(input string name, input logic [3:0] com, input logic [7:0] font);
      step();
      for (int i = 0; i < 24; i++) begin
         if (o_fndCom === com) break;
         step();
      end
      lit(name, com, font);
   endtask

   task automatic load_pulse(input logic [3:0] res, input logic [1:0] op);
      i_load = 1'b1; i_result = res; i_selOperatior = op;
      step();
      i_load = 1'b0;
   endtask

   initial begin
      logic [7:0] t2_font [4];
      logic [3:0] prev_com;
      logic [3:0] last_res;
      t2_font = '{8'hF8, 8'hFF, 8'hFF, 8'h88};

      reset = 1'b1; i_load = 1'b0; i_result = 4'd0; i_selOperatior = 2'b00;
      repeat (3) step();
      lit("reset_dark", 4'hF, 8'hFF);

      // First edge after release still shows the reset value; 7/add is captured on it.
      reset = 1'b0;
      i_load = 1'b1; i_result = 4'd7; i_selOperatior = 2'b00;
      step();
      i_load = 1'b0;
      lit("first_edge", 4'hE, 8'hC0);
      for (int i = 1; i <= 16; i++) begin
         step();
         lit("scan_7_add", com_tbl[(i / 4) % 4], t2_font[(i / 4) % 4]);
      end

      load_pulse(4'd13, 2'b11);
      lit_slot("v13_ones", 4'hE, 8'hB0);
      lit_slot("v13_tens", 4'hD, 8'hF9);
      lit_slot("v13_op", 4'h7, 8'hA1);

      load_pulse(4'd10, 2'b10);
      lit_slot("v10_ones", 4'hE, 8'hC0);
      lit_slot("v10_tens", 4'hD, 8'hF9);
      lit_slot("v10_op", 4'h7, 8'h89);

      // Align to the slot boundary, then load on the edge that advances the scan.
      prev_com = o_fndCom;
      for (int i = 0; i < 10; i++) begin
         step();
         if (o_fndCom !== prev_com) break;
      end
      prev_com = o_fndCom;
      step(); step();
      load_pulse(4'd9, 2'b01);
      step();
      lit("tick_load_order", {prev_com[2:0], prev_com[3]}, o_fndFont);
      check("tick_load_rotate", {4'h0, o_fndCom}, {4'h0, prev_com[2:0], prev_com[3]});
      lit_slot("v9_ones", 4'hE, 8'h90);
      lit_slot("v9_op", 4'h7, 8'hBF);

      i_load = 1'b1;
      last_res = 4'd0;
      for (int i = 0; i < 10; i++) begin
         last_res = 4'($urandom_range(0, 15));
         i_result = last_res;
         i_selOperatior = 2'($urandom_range(0, 3));
         step();
      end
      i_load = 1'b0;
      lit_slot("held_ones", 4'hE, digit_font[last_res % 10]);
      lit_slot("held_tens", 4'hD, (last_res >= 10) ? 8'hF9 : 8'hFF);

      load_pulse(4'd15, 2'b11);
      lit_slot("v15_op", 4'h7, 8'hA1);
      reset = 1'b1;
      step();
      lit("mid_scan_reset", 4'hF, 8'hFF);
      reset = 1'b0;
      step();
      lit("restart_idx0", 4'hE, 8'hC0);
      lit_slot("restart_op", 4'h7, 8'h88);

      for (int i = 0; i < 1000; i++) begin
         i_load = ($urandom_range(0, 3) == 0);
         i_result = 4'($urandom_range(0, 15));
         i_selOperatior = 2'($urandom_range(0, 3));
         step();
      end
      i_load = 1'b0;
      step();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
